// File: rtl/local_bias_seq.sv
// Supply-qualified bias sequencer: NUM_CH current channels plus cascode, powered up one channel at a time, with an analog testbus.
// Latency: outputs registered (1 edge); testbus reflects select and next state 1 edge later; ready after debounce + per-channel settle.
// No backpressure; optional auto-retry from FAULT is built when LOCAL_BIAS_SEQ_AUTORETRY_EN is defined.

`ifndef wrealZState
`define wrealZState 1.0e30
`endif

module local_bias_seq #(
  parameter int  NUM_CH          = 4,
  parameter int  CODE_W          = 5,
  parameter real I_LSB           = 25e-6,
  parameter real VCAS_V          = 0.8,
  parameter int  DEBOUNCE_CYCLES = 4,
  parameter int  SETTLE_CYCLES   = 8,
  parameter int  RETRY_CYCLES    = 64,
  parameter int  ATB_SEL_W       = $clog2(NUM_CH + 4)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pdb,
  input  real                            vddana_1p8,
  input  real                            vddana_0p8,
  input  real                            vssana,
  input  logic [NUM_CH-1:0]              ch_ena,
  input  logic [NUM_CH-1:0][CODE_W-1:0]  ch_code,
  input  logic [ATB_SEL_W-1:0]           atb_sel,
  output real                            ibias [NUM_CH],
  output real                            vcas,
  output real                            atb1,
  output real                            atb0,
  output logic                           bias_ready,
  output logic                           fault
);

  localparam real Z_V = `wrealZState;

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_CHECK,
    ST_RAMP,
    ST_READY,
    ST_FAULT
  } state_e;

  state_e                          state_q, state_d;
  logic [DB_W-1:0]                 ok_cnt_q, ok_cnt_d;
  logic [DB_W-1:0]                 bad_cnt_q, bad_cnt_d;
  logic [ST_W-1:0]                 settle_q, settle_d;
  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [NUM_CH-1:0]               ena_q, ena_d;
  logic [NUM_CH-1:0][CODE_W-1:0]   code_q, code_d;
  real                             ibias_q [NUM_CH];
  real                             ibias_d [NUM_CH];
  real                             vcas_q, vcas_d;
  real                             atb1_q, atb1_d;
  real                             atb0_q, atb0_d;
  logic                            ready_q, ready_d;
  logic                            fault_q, fault_d;
  logic                            supply_ok_q;
  logic                            powered_d;

`ifdef LOCAL_BIAS_SEQ_AUTORETRY_EN
  localparam int RT_W = $clog2(RETRY_CYCLES + 1);
  localparam logic [RT_W-1:0] RT_LAST = RT_W'(RETRY_CYCLES - 1);
  logic [RT_W-1:0]                 retry_q, retry_d;
`endif

  logic rail_1p8_ok, rail_0p8_ok, rail_vss_ok, supply_ok;

  // Window comparators on each rail, bounds inclusive.
  always_comb begin
    rail_1p8_ok = (vddana_1p8 >= 1.71)  && (vddana_1p8 <= 1.89);
    rail_0p8_ok = (vddana_0p8 >= 0.76)  && (vddana_0p8 <= 0.84);
    rail_vss_ok = (vssana     >= -0.05) && (vssana     <= 0.05);
    supply_ok   = rail_1p8_ok && rail_0p8_ok && rail_vss_ok;
  end

  // Sequencer next state: pdb drop wins, then debounced supply events, then ramp progress.
  always_comb begin
    state_d   = state_q;
    ok_cnt_d  = ok_cnt_q;
    bad_cnt_d = bad_cnt_q;
    settle_d  = settle_q;
    ptr_d     = ptr_q;
    ena_d     = ena_q;
    code_d    = code_q;
    ibias_d   = ibias_q;
    vcas_d    = vcas_q;
    ready_d   = ready_q;
    fault_d   = fault_q;
`ifdef LOCAL_BIAS_SEQ_AUTORETRY_EN
    retry_d   = retry_q;
`endif
    if (!pdb) begin
      state_d   = ST_OFF;
      ok_cnt_d  = '0;
      bad_cnt_d = '0;
      settle_d  = '0;
      ptr_d     = '0;
      for (int i = 0; i < NUM_CH; i++) ibias_d[i] = Z_V;
      vcas_d    = Z_V;
      ready_d   = 1'b0;
      fault_d   = 1'b0;
`ifdef LOCAL_BIAS_SEQ_AUTORETRY_EN
      retry_d   = '0;
`endif
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d  = ST_CHECK;
          ok_cnt_d = '0;
        end
        ST_CHECK: begin
          if (!supply_ok) begin
            ok_cnt_d = '0;
          end else if (ok_cnt_q == DB_LAST) begin
            // Supplies qualified: snapshot the channel setup and bring up channel 0 now.
            state_d   = ST_RAMP;
            ok_cnt_d  = '0;
            bad_cnt_d = '0;
            settle_d  = '0;
            ptr_d     = '0;
            ena_d     = ch_ena;
            code_d    = ch_code;
            vcas_d    = VCAS_V;
            for (int i = 0; i < NUM_CH; i++) ibias_d[i] = Z_V;
            if (ch_ena[0]) ibias_d[0] = I_LSB * real'(ch_code[0]);
          end else begin
            ok_cnt_d = ok_cnt_q + DB_W'(1);
          end
        end
        ST_RAMP, ST_READY: begin
          bad_cnt_d = supply_ok ? '0 : bad_cnt_q + DB_W'(1);
          if (!supply_ok && (bad_cnt_q == DB_LAST)) begin
            state_d   = ST_FAULT;
            bad_cnt_d = '0;
            for (int i = 0; i < NUM_CH; i++) ibias_d[i] = Z_V;
            vcas_d    = Z_V;
            ready_d   = 1'b0;
            fault_d   = 1'b1;
`ifdef LOCAL_BIAS_SEQ_AUTORETRY_EN
            retry_d   = '0;
`endif
          end else if (state_q == ST_RAMP) begin
            // Short supply glitches are only counted; the ramp keeps moving.
            if (!ena_q[ptr_q] || (settle_q == ST_LAST)) begin
              settle_d = '0;
              if (ptr_q == PTR_LAST) begin
                state_d = ST_READY;
                ready_d = 1'b1;
                fault_d = 1'b0;
              end else begin
                ptr_d = ptr_q + PTR_W'(1);
                if (ena_q[ptr_d]) ibias_d[ptr_d] = I_LSB * real'(code_q[ptr_d]);
              end
            end else begin
              settle_d = settle_q + ST_W'(1);
            end
          end
        end
        ST_FAULT: begin
`ifdef LOCAL_BIAS_SEQ_AUTORETRY_EN
          // fault stays asserted through the retry until READY is reached again.
          if (retry_q == RT_LAST) begin
            state_d  = ST_CHECK;
            ok_cnt_d = '0;
            retry_d  = '0;
          end else begin
            retry_d = retry_q + RT_W'(1);
          end
`else
          state_d = ST_FAULT;
`endif
        end
        default: state_d = ST_OFF;
      endcase
    end

    // Testbus follows the state being entered so it never shows stale bias after a shutdown.
    powered_d = (state_d == ST_RAMP) || (state_d == ST_READY);
    atb1_d    = Z_V;
    atb0_d    = Z_V;
    if (state_d != ST_OFF) begin
      if (atb_sel == ATB_SEL_W'(1)) begin
        atb1_d = vddana_1p8;
        atb0_d = vssana;
      end else if (atb_sel == ATB_SEL_W'(2)) begin
        atb1_d = vddana_0p8;
        atb0_d = vssana;
      end else if (powered_d && (atb_sel == ATB_SEL_W'(3))) begin
        atb1_d = vcas_d;
        atb0_d = vssana;
      end else if (powered_d) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (atb_sel == ATB_SEL_W'(k + 4)) begin
            atb1_d = ibias_d[k];
            atb0_d = vssana;
          end
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OFF;
      ok_cnt_q  <= '0;
      bad_cnt_q <= '0;
      settle_q  <= '0;
      ptr_q     <= '0;
      ena_q     <= '0;
      code_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) ibias_q[i] <= Z_V;
      vcas_q    <= Z_V;
      atb1_q    <= Z_V;
      atb0_q    <= Z_V;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
`ifdef LOCAL_BIAS_SEQ_AUTORETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ok_cnt_q  <= ok_cnt_d;
      bad_cnt_q <= bad_cnt_d;
      settle_q  <= settle_d;
      ptr_q     <= ptr_d;
      ena_q     <= ena_d;
      code_q    <= code_d;
      for (int i = 0; i < NUM_CH; i++) ibias_q[i] <= ibias_d[i];
      vcas_q    <= vcas_d;
      atb1_q    <= atb1_d;
      atb0_q    <= atb0_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
`ifdef LOCAL_BIAS_SEQ_AUTORETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  // Announce each loss of supply qualification once, naming the first rail found out of range.
  always_ff @(posedge clk) begin
    if (rst) begin
      supply_ok_q <= 1'b0;
    end else begin
      supply_ok_q <= supply_ok;
      if (supply_ok_q && !supply_ok) begin
        if (!rail_1p8_ok)      $warning("local_bias_seq: vddana_1p8 out of range (%f V)", vddana_1p8);
        else if (!rail_0p8_ok) $warning("local_bias_seq: vddana_0p8 out of range (%f V)", vddana_0p8);
        else                   $warning("local_bias_seq: vssana out of range (%f V)", vssana);
      end
    end
  end

  assign ibias      = ibias_q;
  assign vcas       = vcas_q;
  assign atb1       = atb1_q;
  assign atb0       = atb0_q;
  assign bias_ready = ready_q;
  assign fault      = fault_q;

endmodule
